// File: rtl/mod_counter_ext_if.sv
// Control/status bundle for mod_counter_ext; the wrap counter field exists only
// when MOD_COUNTER_WRAP_CNT_EN is defined.
interface mod_counter_ext_if #(
  parameter int NUM = 16
);
  localparam int W  = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int MW = $clog2(NUM + 1);

  logic          en_sig;
  logic          clr_sig;
  logic          load_sig;
  logic [W-1:0]  load_val_sig;
  logic          dir_sig;
  logic [MW-1:0] mod_sig;
  logic          start_sig;
  logic [W-1:0]  counter_sig;
  logic          tc_sig;
  logic          busy_sig;
`ifdef MOD_COUNTER_WRAP_CNT_EN
  logic [15:0]   wrap_cnt_sig;
`endif

  modport slave (
    input  en_sig, clr_sig, load_sig, load_val_sig, dir_sig, mod_sig, start_sig,
`ifdef MOD_COUNTER_WRAP_CNT_EN
    output wrap_cnt_sig,
`endif
    output counter_sig, tc_sig, busy_sig
  );

  modport master (
    output en_sig, clr_sig, load_sig, load_val_sig, dir_sig, mod_sig, start_sig,
`ifdef MOD_COUNTER_WRAP_CNT_EN
    input  wrap_cnt_sig,
`endif
    input  counter_sig, tc_sig, busy_sig
  );
endinterface

// File: rtl/mod_counter_ext.sv
// Run-time modulus up/down counter with wrap pulse and optional one-shot timer FSM.
// Optional saturating wrap counter output: define MOD_COUNTER_WRAP_CNT_EN.
module mod_counter_ext #(
  parameter int NUM      = 16,
  parameter int ONE_SHOT = 0
) (
  input  logic            clk_sig,
  input  logic            reset_sig,
  mod_counter_ext_if.slave bus
);
  localparam int W  = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int MW = $clog2(NUM + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  cnt;
  logic          tc;
  logic          busy;
  logic [MW-1:0] m_eff;
  logic [MW-1:0] m_last;
  logic [MW-1:0] cnt_ext;
  logic [MW-1:0] ld_ext;
  logic [W-1:0]  step_cnt;
  logic          step_tc;
  logic          step_done;

`ifdef MOD_COUNTER_WRAP_CNT_EN
  logic [15:0]   wrap_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  // Next count for an enabled step; comparisons in MW bits so M=NUM cannot overflow.
  always_comb begin
    m_eff     = (bus.mod_sig == '0) ? MW'(NUM) : bus.mod_sig;
    m_last    = m_eff - MW'(1);
    cnt_ext   = MW'(cnt);
    ld_ext    = MW'(bus.load_val_sig);
    step_cnt  = cnt;
    step_tc   = 1'b0;
    step_done = 1'b0;
    if (ONE_SHOT != 0) begin
      if (!bus.dir_sig) begin
        if ((cnt_ext >= m_last) || (cnt_ext + MW'(1) == m_last)) begin
          step_cnt  = W'(m_last);
          step_tc   = 1'b1;
          step_done = 1'b1;
        end else begin
          step_cnt = cnt + W'(1);
        end
      end else if (cnt_ext > m_last) begin
        step_cnt = W'(m_last);
      end else if (cnt_ext <= MW'(1)) begin
        step_cnt  = '0;
        step_tc   = 1'b1;
        step_done = 1'b1;
      end else begin
        step_cnt = cnt - W'(1);
      end
    end else begin
      if (!bus.dir_sig) begin
        if (cnt_ext >= m_last) begin
          step_cnt = '0;
          step_tc  = 1'b1;
        end else begin
          step_cnt = cnt + W'(1);
        end
      end else if (cnt == '0) begin
        step_cnt = W'(m_last);
        step_tc  = 1'b1;
      end else if (cnt_ext > m_last) begin
        step_cnt = W'(m_last);
      end else begin
        step_cnt = cnt - W'(1);
      end
    end
  end

  // Priority: clear, load, start (one-shot only), enabled step.
  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      cnt   <= '0;
      tc    <= 1'b0;
      state <= (ONE_SHOT != 0) ? IDLE : RUN;
      busy  <= (ONE_SHOT == 0);
`ifdef MOD_COUNTER_WRAP_CNT_EN
      wrap_cnt <= '0;
`endif
    end else begin
      tc <= 1'b0;
      if (bus.clr_sig) begin
        cnt <= '0;
        if (ONE_SHOT != 0) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
`ifdef MOD_COUNTER_WRAP_CNT_EN
        wrap_cnt <= '0;
`endif
      end else if (bus.load_sig) begin
        cnt <= (ld_ext > m_last) ? W'(m_last) : bus.load_val_sig;
      end else if ((ONE_SHOT != 0) && bus.start_sig && (state != RUN)) begin
        state <= RUN;
        busy  <= 1'b1;
        cnt   <= bus.dir_sig ? W'(m_last) : '0;
      end else if (bus.en_sig && (state == RUN)) begin
        cnt <= step_cnt;
        tc  <= step_tc;
        if (step_done) begin
          state <= DONE;
          busy  <= 1'b0;
        end
`ifdef MOD_COUNTER_WRAP_CNT_EN
        if (step_tc) wrap_cnt <= sat_inc(wrap_cnt);
`endif
      end
    end
  end

  assign bus.counter_sig = cnt;
  assign bus.tc_sig      = tc;
  assign bus.busy_sig    = busy;
`ifdef MOD_COUNTER_WRAP_CNT_EN
  assign bus.wrap_cnt_sig = wrap_cnt;
`endif
endmodule

// File: tb/tb_mod_counter_ext.sv
// Bench for mod_counter_ext: a free-running and a one-shot instance driven alike,
// checked every cycle against an integer reference model plus literal pins.
module tb_mod_counter_ext;
  localparam int NUM = 16;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  logic clk_sig;
  logic reset_sig;

  mod_counter_ext_if #(.NUM(NUM)) fr_if ();
  mod_counter_ext_if #(.NUM(NUM)) os_if ();

  mod_counter_ext #(.NUM(NUM), .ONE_SHOT(0)) dut_fr (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .bus(fr_if.slave));
  mod_counter_ext #(.NUM(NUM), .ONE_SHOT(1)) dut_os (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .bus(os_if.slave));

  initial clk_sig = 1'b0;
  always #5 clk_sig = ~clk_sig;

  int errors = 0;
  int checks = 0;

  int in_en, in_clr, in_load, in_lv, in_dir, in_mod, in_start;
  int fr_c, fr_t, fr_w;
  int os_c, os_t, os_w, os_st;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input int en, input int clr, input int load, input int lv,
                        input int dir, input int md, input int start);
    in_en = en; in_clr = clr; in_load = load; in_lv = lv;
    in_dir = dir; in_mod = md; in_start = start;
    fr_if.en_sig = 1'(en);   os_if.en_sig = 1'(en);
    fr_if.clr_sig = 1'(clr); os_if.clr_sig = 1'(clr);
    fr_if.load_sig = 1'(load); os_if.load_sig = 1'(load);
    fr_if.load_val_sig = 4'(lv); os_if.load_val_sig = 4'(lv);
    fr_if.dir_sig = 1'(dir); os_if.dir_sig = 1'(dir);
    fr_if.mod_sig = 5'(md);  os_if.mod_sig = 5'(md);
    fr_if.start_sig = 1'(start); os_if.start_sig = 1'(start);
  endtask

  task automatic model_reset();
    fr_c = 0; fr_t = 0; fr_w = 0;
    os_c = 0; os_t = 0; os_w = 0; os_st = S_IDLE;
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // One clock edge of the spec's rules, expressed on plain integers.
  task automatic model_step();
    int m;
    m = (in_mod == 0) ? NUM : in_mod;
    fr_t = 0;
    if (in_clr != 0) begin
      fr_c = 0; fr_w = 0;
    end else if (in_load != 0) begin
      fr_c = (in_lv < m - 1) ? in_lv : m - 1;
    end else if (in_en != 0) begin
      if (in_dir == 0) begin
        if (fr_c > m - 1) begin fr_c = 0; fr_t = 1; end
        else begin fr_c = (fr_c + 1) % m; fr_t = (fr_c == 0); end
      end else begin
        if (fr_c > m - 1) fr_c = m - 1;
        else begin fr_t = (fr_c == 0); fr_c = (fr_c + m - 1) % m; end
      end
      if (fr_t != 0) fr_w = sat16(fr_w + 1);
    end

    os_t = 0;
    if (in_clr != 0) begin
      os_c = 0; os_w = 0; os_st = S_IDLE;
    end else if (in_load != 0) begin
      os_c = (in_lv < m - 1) ? in_lv : m - 1;
    end else if (in_start != 0 && os_st != S_RUN) begin
      os_st = S_RUN;
      os_c = (in_dir != 0) ? m - 1 : 0;
    end else if (in_en != 0 && os_st == S_RUN) begin
      if (in_dir == 0) begin
        os_c = (os_c + 1 < m - 1) ? os_c + 1 : m - 1;
        if (os_c == m - 1) begin os_t = 1; os_st = S_DONE; end
      end else if (os_c > m - 1) begin
        os_c = m - 1;
      end else begin
        os_c = (os_c - 1 > 0) ? os_c - 1 : 0;
        if (os_c == 0) begin os_t = 1; os_st = S_DONE; end
      end
      if (os_t != 0) os_w = sat16(os_w + 1);
    end
  endtask

  task automatic compare_all();
    chk("fr_counter", int'(fr_if.counter_sig), fr_c);
    chk("fr_tc", int'(fr_if.tc_sig), fr_t);
    chk("fr_busy", int'(fr_if.busy_sig), 1);
    chk("os_counter", int'(os_if.counter_sig), os_c);
    chk("os_tc", int'(os_if.tc_sig), os_t);
    chk("os_busy", int'(os_if.busy_sig), (os_st == S_RUN) ? 1 : 0);
`ifdef MOD_COUNTER_WRAP_CNT_EN
    chk("fr_wrap_cnt", int'(fr_if.wrap_cnt_sig), fr_w);
    chk("os_wrap_cnt", int'(os_if.wrap_cnt_sig), os_w);
`endif
  endtask

  task automatic cycle();
    @(posedge clk_sig);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    reset_sig = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk_sig);
    #1;
    chk("rst_fr_counter", int'(fr_if.counter_sig), 0);
    chk("rst_fr_busy", int'(fr_if.busy_sig), 1);
    chk("rst_os_busy", int'(os_if.busy_sig), 0);
    compare_all();
    reset_sig = 1'b1;

    // Up count, full modulus: period 16, tc with the reappearing 0.
    set_in(1, 0, 0, 0, 0, 0, 0);
    repeat (16) cycle();
    chk("t1_wrap_cnt", int'(fr_if.counter_sig), 0);
    chk("t1_wrap_tc", int'(fr_if.tc_sig), 1);
    repeat (16) cycle();
    chk("t1_period_tc", int'(fr_if.tc_sig), 1);

    // Down count, modulus 10.
    set_in(1, 1, 0, 0, 1, 10, 0); cycle();
    set_in(1, 0, 0, 0, 1, 10, 0); cycle();
    chk("t2_first", int'(fr_if.counter_sig), 9);
    chk("t2_first_tc", int'(fr_if.tc_sig), 1);
    repeat (9) cycle();
    chk("t2_zero", int'(fr_if.counter_sig), 0);
    chk("t2_zero_tc", int'(fr_if.tc_sig), 0);
    cycle();
    chk("t2_rewrap", int'(fr_if.counter_sig), 9);

    // Load clamp, then clear beating load.
    set_in(1, 0, 1, 7, 0, 5, 0); cycle();
    chk("t3_load_clamp", int'(fr_if.counter_sig), 4);
    chk("t3_load_tc", int'(fr_if.tc_sig), 0);
    set_in(1, 1, 1, 7, 0, 5, 0); cycle();
    chk("t3_clr_wins", int'(fr_if.counter_sig), 0);

    // Modulus shrinks under a count left out of range.
    set_in(1, 0, 0, 0, 0, 0, 0);
    repeat (12) cycle();
    chk("t4_at12", int'(fr_if.counter_sig), 12);
    set_in(1, 0, 0, 0, 0, 4, 0); cycle();
    chk("t4_clamp", int'(fr_if.counter_sig), 0);
    chk("t4_clamp_tc", int'(fr_if.tc_sig), 1);
    repeat (3) cycle();
    chk("t4_at3", int'(fr_if.counter_sig), 3);
    cycle();
    chk("t4_wrap_tc", int'(fr_if.tc_sig), 1);

    // One-shot run with an ignored mid-run start and a restart from DONE.
    set_in(1, 1, 0, 0, 0, 6, 0); cycle();
    set_in(1, 0, 0, 0, 0, 6, 1); cycle();
    chk("t5_start_cnt", int'(os_if.counter_sig), 0);
    chk("t5_start_busy", int'(os_if.busy_sig), 1);
    set_in(1, 0, 0, 0, 0, 6, 0); cycle(); cycle();
    set_in(1, 0, 0, 0, 0, 6, 1); cycle();
    chk("t5_ignored_start", int'(os_if.counter_sig), 3);
    set_in(1, 0, 0, 0, 0, 6, 0); cycle(); cycle();
    chk("t5_terminal", int'(os_if.counter_sig), 5);
    chk("t5_terminal_tc", int'(os_if.tc_sig), 1);
    chk("t5_done_busy", int'(os_if.busy_sig), 0);
    repeat (3) cycle();
    chk("t5_hold", int'(os_if.counter_sig), 5);
    set_in(1, 0, 0, 0, 0, 6, 1); cycle();
    chk("t5_restart", int'(os_if.counter_sig), 0);
    chk("t5_restart_busy", int'(os_if.busy_sig), 1);

    // Asynchronous reset mid-count.
    set_in(1, 1, 0, 0, 0, 0, 0); cycle();
    set_in(1, 0, 0, 0, 0, 0, 0);
    repeat (9) cycle();
    chk("t6_at9", int'(fr_if.counter_sig), 9);
    reset_sig = 1'b0;
    model_reset();
    #1;
    chk("t6_async_cnt", int'(fr_if.counter_sig), 0);
    chk("t6_async_tc", int'(fr_if.tc_sig), 0);
    compare_all();
    @(posedge clk_sig);
    #1;
    reset_sig = 1'b1;

`ifdef MOD_COUNTER_WRAP_CNT_EN
    set_in(1, 1, 0, 0, 0, 2, 0); cycle();
    set_in(1, 0, 0, 0, 0, 2, 0);
    repeat (40) cycle();
    chk("wrap_cnt_20", int'(fr_if.wrap_cnt_sig), 20);
    set_in(1, 1, 0, 0, 0, 2, 0); cycle();
    chk("wrap_cnt_clr", int'(fr_if.wrap_cnt_sig), 0);
`endif

    // Randomized traffic, including out-of-range counts and modulus 1.
    for (int i = 0; i < 1500; i++) begin
      int md, dr;
      md = in_mod;
      dr = in_dir;
      if ($urandom_range(0, 19) == 0) md = $urandom_range(0, 16);
      if ($urandom_range(0, 29) == 0) dr = 1 - dr;
      set_in(($urandom_range(0, 9) < 8) ? 1 : 0,
             ($urandom_range(0, 99) < 3) ? 1 : 0,
             ($urandom_range(0, 99) < 5) ? 1 : 0,
             $urandom_range(0, 15), dr, md,
             ($urandom_range(0, 9) == 0) ? 1 : 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
